// File: rtl/lsu_pkg.sv
// lsu_pkg: shared state encoding, access-size codes and alignment helper for the LSU.
package lsu_pkg;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    localparam int TIMEOUT_DEF = 255;

    // Reserved size 3 behaves as a word, so anything but byte/half uses lane 0.
    function automatic logic [1:0] byte_offset(input logic [1:0] size, input logic [1:0] addr);
        return size == SZ_B ? addr : size == SZ_H ? {addr[1], 1'b0} : 2'b00;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// lsu_align: store lane mask/data shift and load extraction with sign/zero extension.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  addr,
    input  logic [1:0]  size,
    input  logic        uns,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [7:0]  wmask,
    output logic [31:0] wdata_sh,
    output logic [31:0] rdata_ext
);

    logic [1:0]  off;
    logic [31:0] sh;

    always_comb begin
        off       = byte_offset(size, addr);
        wmask     = size == SZ_B ? 8'h01 << off : size == SZ_H ? 8'h03 << off : 8'h0F;
        wdata_sh  = wdata << {off, 3'b000};
        sh        = rdata >> {off, 3'b000};
        rdata_ext = size == SZ_B ? {{24{sh[7] & ~uns}}, sh[7:0]} :
                    size == SZ_H ? {{16{sh[15] & ~uns}}, sh[15:0]} : sh;
    end

endmodule

// File: rtl/lsu.sv
// lsu: load/store unit FSM (IDLE->REQ->WAIT->RESP) with cycle timeout abort.
// Define LSU_MISALIGN_CHECK_EN to trap misaligned half/word accesses without touching memory.
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ren,
    input  logic        in_wen,
    input  logic [31:0] in_addr,
    input  logic [31:0] in_wdata,
    input  logic [1:0]  in_size,
    input  logic        in_unsigned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_rdata,
    output logic        out_err,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_wen,
    output logic [31:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_t        state, state_nx;
    logic [31:0]   addr_q, wdata_q, rdata_q;
    logic [1:0]    size_q;
    logic          uns_q, ren_q, wen_q, err_q;
    logic [CW-1:0] cnt;
    logic [7:0]    wmask;
    logic [31:0]   wdata_sh, rdata_ext;
    logic          accept, access, busy, timeout, trap;

    assign accept  = in_valid && in_ready;
    assign access  = in_ren || in_wen;
    assign busy    = state == S_REQ || state == S_WAIT;
    assign timeout = cnt == CW'(TIMEOUT - 1);

`ifdef LSU_MISALIGN_CHECK_EN
    assign trap = access && ((in_size == SZ_H && in_addr[0]) || (in_size[1] && in_addr[1:0] != 2'b00));
`else
    assign trap = 1'b0;
`endif

    lsu_align u_align (
        .addr      (addr_q[1:0]),
        .size      (size_q),
        .uns       (uns_q),
        .wdata     (wdata_q),
        .rdata     (mem_rdata),
        .wmask     (wmask),
        .wdata_sh  (wdata_sh),
        .rdata_ext (rdata_ext)
    );

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE:  if (accept) state_nx = (!access || trap) ? S_RESP : S_REQ;
            S_REQ:   state_nx = timeout ? S_RESP : mem_ready ? S_WAIT : S_REQ;
            S_WAIT:  state_nx = (mem_rvalid || timeout) ? S_RESP : S_WAIT;
            S_RESP:  if (out_ready) state_nx = S_IDLE;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            uns_q   <= 1'b0;
            ren_q   <= 1'b0;
            wen_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                addr_q  <= in_addr;
                wdata_q <= in_wdata;
                size_q  <= in_size;
                uns_q   <= in_unsigned;
                ren_q   <= in_ren;
                wen_q   <= in_wen;
                rdata_q <= '0;
                err_q   <= trap;
                cnt     <= '0;
            end
            if (busy)
                cnt <= cnt + 1'b1;
            // A response arriving on the timeout cycle still wins.
            if (state == S_WAIT && mem_rvalid)
                rdata_q <= (ren_q && !wen_q) ? rdata_ext : '0;
            else if (busy && timeout) begin
                err_q   <= 1'b1;
                rdata_q <= '0;
            end
        end
    end

    assign in_ready  = rst_n && state == S_IDLE;
    assign mem_valid = state == S_REQ;
    assign mem_addr  = mem_valid ? {addr_q[31:2], 2'b00} : '0;
    assign mem_wen   = mem_valid && wen_q;
    assign mem_wdata = mem_wen ? wdata_sh : '0;
    assign mem_wmask = mem_wen ? wmask : '0;
    assign out_valid = state == S_RESP;
    assign out_rdata = out_valid ? rdata_q : '0;
    assign out_err   = out_valid && err_q;

endmodule

// File: tb/tb_lsu.sv
// tb_lsu: table-driven LSU bench with a response scoreboard plus timeout and reset sequences.
module tb_lsu;
    import lsu_pkg::*;

    typedef struct {
        logic        ren, wen;
        logic [31:0] addr, wdata;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] mrdata;
        logic        mem;
        logic [31:0] e_maddr, e_mwdata;
        logic [7:0]  e_mask;
        logic [31:0] e_rdata;
        logic        e_err;
        int          mstall, ostall;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    logic        clk, rst_n;
    logic        in_valid, in_ren, in_wen, in_unsigned, out_ready, mem_ready, mem_rvalid;
    logic [31:0] in_addr, in_wdata, mem_rdata;
    logic [1:0]  in_size;
    logic        in_ready, out_valid, out_err, mem_valid, mem_wen;
    logic [31:0] out_rdata, mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        t_in_ready, t_out_valid, t_out_err, t_mem_valid, t_mem_wen;
    logic [31:0] t_out_rdata, t_mem_addr, t_mem_wdata;
    logic [7:0]  t_mem_wmask;

    int n_pass, n_total, hs_cnt;
    vec_t  vecs[$];
    resp_t sb[$];

    lsu dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_ren(in_ren), .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_size(in_size), .in_unsigned(in_unsigned), .out_valid(out_valid),
        .out_ready(out_ready), .out_rdata(out_rdata), .out_err(out_err),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    lsu #(.TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(t_in_ready),
        .in_ren(in_ren), .in_wen(in_wen), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_size(in_size), .in_unsigned(in_unsigned), .out_valid(t_out_valid),
        .out_ready(out_ready), .out_rdata(t_out_rdata), .out_err(t_out_err),
        .mem_valid(t_mem_valid), .mem_ready(mem_ready), .mem_addr(t_mem_addr),
        .mem_wen(t_mem_wen), .mem_wdata(t_mem_wdata), .mem_wmask(t_mem_wmask),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (out_valid && out_ready) hs_cnt <= hs_cnt + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, act, exp);
    endtask

    function automatic vec_t mk(logic ren, logic wen, logic [31:0] addr, logic [31:0] wdata,
                                logic [1:0] size, logic uns, logic [31:0] mrdata, logic mem,
                                logic [31:0] e_maddr, logic [31:0] e_mwdata, logic [7:0] e_mask,
                                logic [31:0] e_rdata, logic e_err, int mstall, int ostall);
        vec_t v;
        v.ren = ren; v.wen = wen; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns;
        v.mrdata = mrdata; v.mem = mem; v.e_maddr = e_maddr; v.e_mwdata = e_mwdata;
        v.e_mask = e_mask; v.e_rdata = e_rdata; v.e_err = e_err; v.mstall = mstall; v.ostall = ostall;
        return v;
    endfunction

    task automatic run_txn(input vec_t v, input int k);
        resp_t r;
        int base, n;
        @(negedge clk);
        chk($sformatf("v%0d in_ready", k), in_ready, 1);
        in_valid = 1; in_ren = v.ren; in_wen = v.wen; in_addr = v.addr;
        in_wdata = v.wdata; in_size = v.size; in_unsigned = v.uns;
        @(posedge clk); #1;
        in_valid = 0; in_ren = 0; in_wen = 0; in_addr = $urandom; in_wdata = $urandom;
        r.rdata = v.e_rdata; r.err = v.e_err;
        sb.push_back(r);
        base = hs_cnt;
        if (v.mem) begin
            for (int i = 0; i <= v.mstall; i++) begin
                @(negedge clk);
                chk($sformatf("v%0d mem_valid", k), mem_valid, 1);
                chk($sformatf("v%0d mem_addr", k), mem_addr, v.e_maddr);
                chk($sformatf("v%0d mem_wen", k), mem_wen, v.wen);
                if (v.wen) begin
                    chk($sformatf("v%0d mem_wmask", k), mem_wmask, v.e_mask);
                    chk($sformatf("v%0d mem_wdata", k), mem_wdata, v.e_mwdata);
                end
                mem_ready = (i == v.mstall);
                @(posedge clk); #1;
                mem_ready = 0;
            end
            @(negedge clk);
            chk($sformatf("v%0d mem_valid in wait", k), mem_valid, 0);
            mem_rvalid = 1; mem_rdata = v.mrdata;
            @(posedge clk); #1;
            mem_rvalid = 0; mem_rdata = $urandom;
        end
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!v.mem) chk($sformatf("v%0d no mem access", k), mem_valid, 0);
        r = sb.pop_front();
        for (int i = 0; i <= v.ostall; i++) begin
            chk($sformatf("v%0d out_valid", k), out_valid, 1);
            chk($sformatf("v%0d out_rdata", k), out_rdata, r.rdata);
            chk($sformatf("v%0d out_err", k), out_err, r.err);
            out_ready = (i == v.ostall);
            @(posedge clk); #1;
            out_ready = 0;
            @(negedge clk);
        end
        chk($sformatf("v%0d out_valid drop", k), out_valid, 0);
        chk($sformatf("v%0d in_ready back", k), in_ready, 1);
        chk($sformatf("v%0d handshakes", k), hs_cnt - base, 1);
    endtask

    initial begin
        vecs.push_back(mk(1, 0, 32'h80000003, 0, SZ_B, 0, 32'h80FF1234, 1, 32'h80000000, 0, 0, 32'hFFFFFF80, 0, 5, 3));
        vecs.push_back(mk(1, 0, 32'h80000003, 0, SZ_B, 1, 32'h80FF1234, 1, 32'h80000000, 0, 0, 32'h00000080, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h80000002, 0, SZ_H, 0, 32'h80FF1234, 1, 32'h80000000, 0, 0, 32'hFFFF80FF, 0, 1, 0));
        vecs.push_back(mk(1, 0, 32'h80000000, 0, SZ_H, 1, 32'h80FF9234, 1, 32'h80000000, 0, 0, 32'h00009234, 0, 0, 1));
        vecs.push_back(mk(1, 0, 32'h80000000, 0, SZ_H, 0, 32'h00007FFF, 1, 32'h80000000, 0, 0, 32'h00007FFF, 0, 0, 0));
        vecs.push_back(mk(1, 0, 32'h80000004, 0, SZ_W, 0, 32'hCAFEBABE, 1, 32'h80000004, 0, 0, 32'hCAFEBABE, 0, 2, 2));
        vecs.push_back(mk(1, 0, 32'h80000001, 0, SZ_B, 0, 32'h1234ABCD, 1, 32'h80000000, 0, 0, 32'hFFFFFFAB, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000002, 32'h0000ABCD, SZ_H, 0, 32'h11111111, 1, 32'h80000000, 32'hABCD0000, 8'h0C, 0, 0, 3, 1));
        vecs.push_back(mk(0, 1, 32'h80000001, 32'h000000EE, SZ_B, 0, 32'h22222222, 1, 32'h80000000, 32'h0000EE00, 8'h02, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h8000000C, 32'h12345678, SZ_W, 0, 32'h33333333, 1, 32'h8000000C, 32'h12345678, 8'h0F, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h80000003, 32'h000000A5, SZ_B, 0, 32'h44444444, 1, 32'h80000000, 32'hA5000000, 8'h08, 0, 0, 1, 0));
        vecs.push_back(mk(0, 0, 32'h80000010, 0, SZ_W, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2));
`ifdef LSU_MISALIGN_CHECK_EN
        vecs.push_back(mk(1, 0, 32'h80000001, 0, SZ_W, 0, 32'h11223344, 0, 0, 0, 0, 0, 1, 0, 0));
`else
        vecs.push_back(mk(1, 0, 32'h80000001, 0, SZ_W, 0, 32'h11223344, 1, 32'h80000000, 0, 0, 32'h11223344, 0, 0, 0));
`endif
        vecs.push_back(mk(1, 0, 32'h80000008, 0, 2'd3, 1, 32'h89ABCDEF, 1, 32'h80000008, 0, 0, 32'h89ABCDEF, 0, 0, 0));

        rst_n = 1; in_valid = 0; in_ren = 0; in_wen = 0; in_addr = 0; in_wdata = 0;
        in_size = 0; in_unsigned = 0; out_ready = 0; mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;
        #2 rst_n = 0;
        repeat (2) @(negedge clk);
        chk("reset in_ready", in_ready, 0);
        chk("reset mem_valid", mem_valid, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wmask", mem_wmask, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        chk("reset out_valid", out_valid, 0);
        chk("reset out_rdata", out_rdata, 0);
        chk("reset out_err", out_err, 0);
        rst_n = 1;
        #1 chk("in_ready after release", in_ready, 1);

        foreach (vecs[i]) run_txn(vecs[i], i);

        // Reset in the middle of an access.
        @(negedge clk);
        in_valid = 1; in_ren = 1; in_addr = 32'h80000004; in_size = SZ_W;
        @(posedge clk); #1;
        in_valid = 0; in_ren = 0; mem_ready = 1;
        @(posedge clk); #1;
        mem_ready = 0;
        @(negedge clk);
        rst_n = 0;
        #1;
        chk("midreset in_ready", in_ready, 0);
        chk("midreset mem_valid", mem_valid, 0);
        chk("midreset mem_addr", mem_addr, 0);
        chk("midreset out_valid", out_valid, 0);
        chk("midreset out_rdata", out_rdata, 0);
        chk("midreset out_err", out_err, 0);
        @(negedge clk);
        rst_n = 1;
        #1 chk("midreset release in_ready", in_ready, 1);
        run_txn(vecs[5], 100);

        // Timeout in WAIT on the TIMEOUT=4 instance, then a late response.
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        in_valid = 1; in_ren = 1; in_addr = 32'h80000010; in_size = SZ_W; in_unsigned = 0;
        @(posedge clk); #1;
        in_valid = 0; in_ren = 0; mem_ready = 1;
        @(negedge clk);
        chk("to mem_valid", t_mem_valid, 1);
        chk("to mem_addr", t_mem_addr, 32'h80000010);
        chk("to mem_wen", t_mem_wen, 0);
        @(posedge clk); #1;
        mem_ready = 0;
        chk("to wait mem_valid", t_mem_valid, 0);
        chk("to c1 out_valid", t_out_valid, 0);
        @(posedge clk); #1 chk("to c2 out_valid", t_out_valid, 0);
        @(posedge clk); #1 chk("to c3 out_valid", t_out_valid, 0);
        @(posedge clk); #1;
        chk("to out_valid", t_out_valid, 1);
        chk("to out_err", t_out_err, 1);
        chk("to out_rdata", t_out_rdata, 0);
        @(negedge clk);
        mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_rvalid = 0;
        chk("late rvalid out_valid", t_out_valid, 1);
        chk("late rvalid out_rdata", t_out_rdata, 0);
        chk("late rvalid out_err", t_out_err, 1);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1 out_ready = 0;
        chk("to in_ready back", t_in_ready, 1);

        // Timeout in REQ: store never accepted, mem_valid must drop.
        @(negedge clk); rst_n = 0;
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        in_valid = 1; in_wen = 1; in_addr = 32'h80000010; in_wdata = 32'h12345678; in_size = SZ_W;
        @(posedge clk); #1;
        in_valid = 0; in_wen = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk($sformatf("toreq c%0d mem_valid", c), t_mem_valid, 1);
            chk($sformatf("toreq c%0d mem_wmask", c), t_mem_wmask, 8'h0F);
            chk($sformatf("toreq c%0d mem_wdata", c), t_mem_wdata, 32'h12345678);
        end
        @(posedge clk); #1;
        chk("toreq mem_valid drop", t_mem_valid, 0);
        chk("toreq out_valid", t_out_valid, 1);
        chk("toreq out_err", t_out_err, 1);
        chk("toreq out_rdata", t_out_rdata, 0);
        @(negedge clk); out_ready = 1;
        @(posedge clk); #1 out_ready = 0;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255, giving the maximum cycles spent in REQ+WAIT before abort.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; asynchronous, active-low.
REQ-004 SHALL have port in_valid, input, 1, the upstream (EXU) request is valid.
REQ-005 SHALL have port in_ready, output, 1, LSU can accept a request.
REQ-006 SHALL have port in_ren / in_wen, input, 1 each, load / store request.
REQ-007 SHALL have port in_addr, input, 32, the byte address.
REQ-008 SHALL have port in_wdata, input, 32, the store data, right-aligned.
REQ-009 SHALL have port in_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = reserved (treated as word).
REQ-010 SHALL have port in_unsigned, input, 1, load zero-extends when 1 and sign-extends when 0.
REQ-011 SHALL have port out_valid, output, 1, the response is valid.
REQ-012 SHALL have port out_ready, input, 1, downstream (WBU) accepts the response.
REQ-013 SHALL have port out_rdata, output, 32, the extended load data, or 0 for stores and errors.
REQ-014 SHALL have port out_err, output, 1, the access was aborted.
REQ-015 SHALL have port mem_valid, output, 1, memory request; mem_ready, input, 1, memory accepts the request.
REQ-016 SHALL have port mem_addr, output, 32, word-aligned address {addr[31:2],2'b00}.
REQ-017 SHALL have ports mem_wen, output, 1; mem_wdata, output, 32; mem_wmask, output, 8 (bits 7:4 always 0).
REQ-018 SHALL have port mem_rvalid, input, 1, the memory response / write acknowledge.
REQ-019 SHALL have port mem_rdata, input, 32, the raw memory word.

Function
REQ-020 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE.
REQ-021 SHALL drive in_ready=1 only in IDLE; in_valid&&in_ready latches addr, wdata, size, unsigned, ren and wen.
REQ-022 SHALL go from IDLE to RESP directly, with out_rdata=0 and out_err=0 and no memory access, when an accepted request has ren=wen=0.
REQ-023 SHALL hold mem_valid=1 and stable mem_* in REQ until mem_ready, then enter WAIT; mem_valid=0 in all other states.
REQ-024 SHALL enter RESP on mem_rvalid in WAIT, latching the extracted data (loads) or 0 (stores).
REQ-025 SHALL ignore mem_rvalid outside WAIT.
REQ-026 SHALL hold out_valid=1 and a stable response in RESP until out_ready, then return to IDLE; no back-to-back accept occurs in the same cycle.
REQ-027 SHALL give a minimum latency of 3 cycles from accept edge to out_valid (mem_ready=1, mem_rvalid 1 cycle after handshake).
REQ-028 SHALL compute the store mask as: byte 8'h1<<addr[1:0]; half 8'h3<<{addr[1],0}; word 8'hF. mem_wdata = wdata << (8*addr[1:0]).
REQ-029 SHALL form the load result as mem_rdata >> (8*offset), then extend from bit 7 (byte) or bit 15 (half) per in_unsigned; word is passed unchanged.
REQ-030 SHALL count cycles in REQ+WAIT; on reaching TIMEOUT it SHALL enter RESP with out_err=1 and out_rdata=0, dropping mem_valid.

Reset
REQ-031 SHALL on rst_n=0, at any time including mid-access, force IDLE with in_ready=0 during reset and all other outputs and the counter 0; in_ready=1 in the first cycle after release.

Configuration
REQ-032 SHALL, with LSU_MISALIGN_CHECK_EN defined, route a half access with addr[0]=1 or a word access with addr[1:0]!=0 from IDLE directly to RESP with out_err=1, out_rdata=0 and no memory access.
REQ-033 SHALL, without LSU_MISALIGN_CHECK_EN, leave out_err driven only by the timeout, use offset {addr[1],0} for half and 0 for word accesses, and never trap.

Structure
REQ-034 SHALL place the state enum, the size encodings (SZ_B, SZ_H, SZ_W) and the default TIMEOUT constant in package lsu_pkg.
REQ-035 SHALL implement mask, wdata shift and load extraction/extension in the combinational sub-module lsu_align; the FSM and counter stay in lsu.

Verification
REQ-036 Load byte signed: addr 0x80000003, mem_rdata 0x80FF_1234 -> out_rdata 0xFFFF_FF80, out_err=0.
REQ-037 Store half: addr 0x80000002, wdata 0x0000_ABCD -> mem_wmask 8'h0C, mem_wdata 0xABCD_0000, mem_addr 0x80000000.
REQ-038 Backpressure: mem_ready low 5 cycles, then out_ready low 3 cycles -> mem_* and the response held stable; exactly one out_valid&&out_ready.
REQ-039 Timeout: TIMEOUT=4, mem_rvalid never asserted -> out_err=1 and out_rdata=0 after 4 cycles; a late mem_rvalid is ignored.
REQ-040 Misaligned word load to 0x80000001 -> with the macro, out_err=1 and no mem_valid; without it, a load from 0x80000000.
REQ-041 Reset asserted during WAIT -> all outputs 0 immediately; after release a new load completes normally.
